// File: rtl/spi_ram_bridge.sv
// SPI slave fronting a WIDTH x DEPTH RAM: frame = dir bit, 2-bit opcode, WIDTH-bit payload.
// Pointer set/write commit on the last payload edge; reads stream back on MISO MSB first.
module spi_ram_bridge #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter bit AUTO_INC = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic frame_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]    LAST_RX   = CW'(WIDTH + 1);
    localparam logic [CW-1:0]    TX_BITS   = CW'(WIDTH);
    localparam logic [WIDTH:0]   DEPTH_W   = (WIDTH + 1)'(DEPTH);
    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, CMD, RX, WAIT_RD, TX, ERR} state_t;

    state_t           state;
    logic             dir;
    logic [WIDTH:0]   rx_sh;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] wr_ptr;
    logic [WIDTH-1:0] rd_ptr;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] mem [DEPTH];

    // Full frame as it stands on the final RX edge (current MOSI is p[0]).
    logic [WIDTH+1:0] frame;
    logic [1:0]       op;
    logic [WIDTH-1:0] pay;
    logic             last_bit;
    logic             dir_ok;
    logic             wr_ok;
    logic             rd_ok;
    logic             mem_we;
    logic [WIDTH-1:0] rd_word;

    assign frame    = {rx_sh, MOSI};
    assign op       = frame[WIDTH+1:WIDTH];
    assign pay      = frame[WIDTH-1:0];
    assign last_bit = (state == RX) && !SS_n && (bit_cnt == LAST_RX);
    assign dir_ok   = (dir == op[1]);
    assign wr_ok    = ({1'b0, wr_ptr} < DEPTH_W);
    assign rd_ok    = ({1'b0, rd_ptr} < DEPTH_W);
    assign mem_we   = last_bit && dir_ok && (op == 2'b01) && wr_ok;
    assign rd_word  = rd_ok ? mem[rd_ptr[AW-1:0]] : '0;

    function automatic logic [WIDTH-1:0] next_ptr(input logic [WIDTH-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr[AW-1:0]] <= pay;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= 1'b0;
            rx_sh     <= '0;
            bit_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tx_sh     <= '0;
            MISO      <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else if (state != IDLE && SS_n) begin
            // Deselect always wins, including on the final payload edge.
            state <= IDLE;
            busy  <= 1'b0;
            MISO  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!SS_n) begin
                        state     <= CMD;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
                    end
                end
                CMD: begin
                    dir     <= MOSI;
                    bit_cnt <= '0;
                    state   <= RX;
                end
                RX: begin
                    rx_sh   <= {rx_sh[WIDTH-1:0], MOSI};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_RX) begin
                        bit_cnt <= '0;
                        // ERR doubles as the wait-for-deselect sink after a good command.
                        state   <= ERR;
                        if (!dir_ok) begin
                            frame_err <= 1'b1;
                        end else begin
                            case (op)
                                2'b00: wr_ptr <= pay;
                                2'b01: begin
                                    if (!wr_ok)
                                        frame_err <= 1'b1;
                                    else if (AUTO_INC)
                                        wr_ptr <= next_ptr(wr_ptr);
                                end
                                2'b10: rd_ptr <= pay;
                                default: state <= WAIT_RD;
                            endcase
                        end
                    end
                end
                WAIT_RD: begin
                    tx_sh   <= rd_word;
                    bit_cnt <= '0;
                    state   <= TX;
                    if (!rd_ok)
                        frame_err <= 1'b1;
                    else if (AUTO_INC)
                        rd_ptr <= next_ptr(rd_ptr);
                end
                TX: begin
                    if (bit_cnt != TX_BITS) begin
                        MISO    <= tx_sh[WIDTH-1];
                        tx_sh   <= {tx_sh[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        MISO <= 1'b0;
                    end
                end
                ERR: begin
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
